// File: rtl/mem_wb_stage_pkg.sv
// Shared constants and types for the MEM->WB pipeline register.
// Optional HI/LO channel is controlled by the MEM_WB_HILO_EN macro (see top).
package mem_wb_stage_pkg;

    localparam logic        RstEnable    = 1'b0;
    localparam logic        Stop         = 1'b1;
    localparam logic        NoStop       = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;

    // What a lane register does on the next clock edge.
    typedef enum logic [1:0] {
        CtlHold  = 2'd0,
        CtlLoad  = 2'd1,
        CtlClear = 2'd2
    } lane_ctl_e;

    // Number of set bits in a lane-valid vector of up to four lanes.
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'({2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]});
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB bus: memory-stage inputs and registered write-back outputs.
// HI/LO signals exist only when MEM_WB_HILO_EN is defined.
interface mem_wb_stage_if #(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [LANES-1:0]        mem_valid;
    logic [LANES-1:0]        mem_wreg;
    logic [LANES*ADDR_W-1:0] mem_wd;
    logic [LANES*DATA_W-1:0] mem_wdata;
    logic [LANES-1:0]        wb_valid;
    logic [LANES-1:0]        wb_wreg;
    logic [LANES*ADDR_W-1:0] wb_wd;
    logic [LANES*DATA_W-1:0] wb_wdata;
`ifdef MEM_WB_HILO_EN
    logic                    mem_whilo;
    logic [DATA_W-1:0]       mem_hi;
    logic [DATA_W-1:0]       mem_lo;
    logic                    wb_whilo;
    logic [DATA_W-1:0]       wb_hi;
    logic [DATA_W-1:0]       wb_lo;

    modport master (
        output mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
        input  wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo
    );
    modport slave (
        input  mem_valid, mem_wreg, mem_wd, mem_wdata, mem_whilo, mem_hi, mem_lo,
        output wb_valid, wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo
    );
`else
    modport master (
        output mem_valid, mem_wreg, mem_wd, mem_wdata,
        input  wb_valid, wb_wreg, wb_wd, wb_wdata
    );
    modport slave (
        input  mem_valid, mem_wreg, mem_wd, mem_wdata,
        output wb_valid, wb_wreg, wb_wd, wb_wdata
    );
`endif
endinterface

// File: rtl/mem_wb_stage_wb_lane_reg.sv
// One write-back lane register: valid / write-enable / address / data,
// with load, clear (bubble) and hold controls. Writes to register 0 are
// suppressed at load time.
module wb_lane_reg
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  lane_ctl_e         ctl_i,
    input  logic              valid_i,
    input  logic              wreg_i,
    input  logic [ADDR_W-1:0] wd_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              valid_o,
    output logic              wreg_o,
    output logic [ADDR_W-1:0] wd_o,
    output logic [DATA_W-1:0] wdata_o
);

    logic              valid_q, valid_d;
    logic              wreg_q,  wreg_d;
    logic [ADDR_W-1:0] wd_q,    wd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // Next-state selection: hold by default, load or clear on request.
    always_comb begin
        valid_d = valid_q;
        wreg_d  = wreg_q;
        wd_d    = wd_q;
        wdata_d = wdata_q;
        case (ctl_i)
            CtlLoad: begin
                valid_d = valid_i;
                wreg_d  = valid_i & wreg_i & (wd_i != '0);
                wd_d    = wd_i;
                wdata_d = wdata_i;
            end
            CtlClear: begin
                valid_d = 1'b0;
                wreg_d  = WriteDisable;
                wd_d    = '0;
                wdata_d = '0;
            end
            default: ;
        endcase
    end

    // Lane state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            valid_q <= 1'b0;
            wreg_q  <= WriteDisable;
            wd_q    <= '0;
            wdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            wreg_q  <= wreg_d;
            wd_q    <= wd_d;
            wdata_q <= wdata_d;
        end
    end

    assign valid_o = valid_q;
    assign wreg_o  = wreg_q;
    assign wd_o    = wd_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: LANES write-back lanes, stall hold, bubble,
// exception flush and a retired-instruction counter.
// Define MEM_WB_HILO_EN to build the HI/LO write channel (lane 0 only).
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    mem_wb_stage_if.slave      bus,
    output logic [31:0]        retire_cnt_o,
    output logic [2:0]         retire_inc_o
);

    lane_ctl_e         ctl;
    logic              stallSelf;
    logic              stallDown;
    logic              unusedStall;
    logic [2:0]        retirePop;
    logic [31:0]       retireCnt_q, retireCnt_d;
    logic [2:0]        retireInc_q, retireInc_d;

    logic              laneValid [LANES];
    logic              laneWreg  [LANES];
    logic [ADDR_W-1:0] laneWd    [LANES];
    logic [DATA_W-1:0] laneWdata [LANES];

    assign stallSelf   = stall_i[STAGE_IDX];
    assign unusedStall = ^stall_i;

    // The last stage in the stall vector has no downstream neighbour.
    generate
        if (STAGE_IDX == STALL_W - 1) begin : g_no_down
            assign stallDown = NoStop;
        end else begin : g_down
            assign stallDown = stall_i[STAGE_IDX+1];
        end
    endgenerate

    // Control decode: flush beats stall; a stalled stage feeding a running one emits a bubble.
    always_comb begin
        ctl = CtlHold;
        if (flush_i)
            ctl = CtlClear;
        else if (stallSelf == NoStop)
            ctl = CtlLoad;
        else if (stallDown == NoStop)
            ctl = CtlClear;
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            wb_lane_reg #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W)
            ) u_lane (
                .clk     (clk),
                .resetn  (resetn),
                .ctl_i   (ctl),
                .valid_i (bus.mem_valid[i]),
                .wreg_i  (bus.mem_wreg[i]),
                .wd_i    (bus.mem_wd[i*ADDR_W +: ADDR_W]),
                .wdata_i (bus.mem_wdata[i*DATA_W +: DATA_W]),
                .valid_o (laneValid[i]),
                .wreg_o  (laneWreg[i]),
                .wd_o    (laneWd[i]),
                .wdata_o (laneWdata[i])
            );
        end
    endgenerate

    // Pack per-lane registers back onto the write-back bus.
    always_comb begin
        bus.wb_valid = '0;
        bus.wb_wreg  = '0;
        bus.wb_wd    = '0;
        bus.wb_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.wb_valid[i]                  = laneValid[i];
            bus.wb_wreg[i]                   = laneWreg[i];
            bus.wb_wd[i*ADDR_W +: ADDR_W]    = laneWd[i];
            bus.wb_wdata[i*DATA_W +: DATA_W] = laneWdata[i];
        end
    end

    assign retirePop = popcount4(4'(bus.mem_valid));

    // Retire accounting: only a real advance counts; hold and bubble report zero.
    always_comb begin
        retireInc_d = '0;
        retireCnt_d = retireCnt_q;
        if (ctl == CtlLoad) begin
            retireInc_d = retirePop;
            retireCnt_d = retireCnt_q + {29'd0, retirePop};
        end
    end

    // Retire counter registers.
    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            retireCnt_q <= '0;
            retireInc_q <= '0;
        end else begin
            retireCnt_q <= retireCnt_d;
            retireInc_q <= retireInc_d;
        end
    end

    assign retire_cnt_o = retireCnt_q;
    assign retire_inc_o = retireInc_q;

`ifdef MEM_WB_HILO_EN
    logic              whilo_q, whilo_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    // HI/LO channel next state follows the same load/clear/hold control as lane 0.
    always_comb begin
        whilo_d = whilo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (ctl)
            CtlLoad: begin
                whilo_d = bus.mem_valid[0] & bus.mem_whilo;
                hi_d    = bus.mem_hi;
                lo_d    = bus.mem_lo;
            end
            CtlClear: begin
                whilo_d = WriteDisable;
                hi_d    = '0;
                lo_d    = '0;
            end
            default: ;
        endcase
    end

    // HI/LO channel registers.
    always_ff @(posedge clk) begin
        if (resetn == RstEnable) begin
            whilo_q <= WriteDisable;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            whilo_q <= whilo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.wb_whilo = whilo_q;
    assign bus.wb_hi    = hi_q;
    assign bus.wb_lo    = lo_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline register for the multi-issue core: latches up to `LANES` register-file write channels plus an optional HI/LO write channel from the memory stage and presents them to write-back. It supports stall hold, bubble insertion, exception flush, per-lane valid tracking, suppression of writes to register 0, and a retired-instruction counter. It sits between the memory stage and the register file / HI-LO unit, and its outputs also feed the forwarding network.

## Interface
- `LANES`, 2: number of parallel write-back lanes (1–4).
- `DATA_W`, 32: write-data width.
- `ADDR_W`, 5: register-address width.
- `STALL_W`, 6: width of the pipeline stall vector.
- `STAGE_IDX`, 4: bit of `stall` that belongs to this stage; `STAGE_IDX+1` is the downstream stage.

Ports:
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `stall` in `STALL_W`: pipeline stall vector; 1 = stop.
- `flush` in 1: exception flush, kills the entry being latched.
- `mem_valid` in `LANES`: lane carries a real instruction.
- `mem_wreg` in `LANES`: lane writes a GPR.
- `mem_wd` in `LANES*ADDR_W`: destination addresses; lane *i* uses bits [i*ADDR_W +: ADDR_W].
- `mem_wdata` in `LANES*DATA_W`: write data, packed the same way.
- `mem_whilo`, `mem_hi`, `mem_lo` in 1/`DATA_W`/`DATA_W`: HI/LO write channel, lane 0 only. Present only when `MEM_WB_HILO_EN` is defined.
- `wb_valid`, `wb_wreg` out `LANES`: registered valid and GPR write enable per lane.
- `wb_wd`, `wb_wdata` out packed: registered address and data.
- `wb_whilo`, `wb_hi`, `wb_lo` out: registered HI/LO channel (macro only).
- `retire_cnt` out 32: count of retired instructions.
- `retire_inc` out 3: number of lanes retired on the last clock edge.

## Operation
Per clock edge, the first matching row applies:
1. `!resetn`: all outputs go to zero, including `retire_cnt`. `wb_wd` is the NOP address 0.
2. `flush`: insert a bubble. All `wb_*` outputs go to zero and `retire_inc` = 0. `retire_cnt` holds.
3. Bubble: `stall[STAGE_IDX]` = 1 and `stall[STAGE_IDX+1]` = 0. Same effect as flush.
4. Advance: `stall[STAGE_IDX]` = 0. Latch the inputs:
   - `wb_valid[i]` = `mem_valid[i]`.
   - `wb_wreg[i]` = `mem_valid[i] & mem_wreg[i] & (mem_wd_i != 0)`.
   - `wb_wd` and `wb_wdata` are latched unmodified.
   - `wb_whilo` = `mem_valid[0] & mem_whilo`.
   - `retire_inc` = popcount(`mem_valid`).
   - `retire_cnt` += popcount(`mem_valid`), modulo 2^32 (wraps silently).
5. Otherwise (both `stall` bits = 1): hold every output. `retire_inc` goes to 0 so a held entry is never counted twice.

Boundary rules:
- When `STAGE_IDX == STALL_W-1`, the downstream stall is taken as 0.
- `flush` overrides stall.
- Reset asserted mid-stall clears everything on that edge.
- The counter increment is computed at width 3 and zero-extended before the add.

## Timing
- Latency is 1 cycle from MEM inputs to `wb_*` outputs.
- There is no combinational path from any input to any output.
- `retire_cnt` reflects the entry now on `wb_*` in the same cycle it appears.
- All outputs are registered and change only on the rising edge of `clk`.

## Configuration
- `MEM_WB_HILO_EN` defined: HI/LO ports and registers exist and behave as described in Operation.
- Undefined: the HI/LO ports are absent, no HI/LO flops are built, and everything else is unchanged.

## Structure
- Shared package (`define.v` / core package): `RstEnable`, `Stop`/`NoStop`, `ZeroWord`, `NOPRegAddr`, `WriteDisable`.
- One sub-module, `wb_lane_reg`: a single lane's valid/wreg/wd/wdata register with load/clear/hold controls. It is instantiated `LANES` times by a generate loop.
- Control decode, the HI/LO register and the popcount/counter live in the top module.

## Test plan
- Reset: hold `resetn` = 0 for 2 cycles with random inputs → all outputs 0 and `retire_cnt` = 0.
- Advance: `LANES` = 2, lane0 = {valid, wreg, wd 3, 0xDEADBEEF}, lane1 = {valid, wreg, wd 0, 0x1234} → `wb_wreg` = 2'b01, `wb_wdata` lane1 = 0x1234, `retire_inc` = 2, `retire_cnt` = 2.
- Stall/bubble: `stall` = 6'b110000 for 3 cycles → outputs held, `retire_cnt` unchanged. Then `stall` = 6'b010000 → bubble, all `wb_*` = 0.
- Flush with stall: `flush` = 1 and `stall` = 0 with valid inputs → bubble, `retire_cnt` unchanged.
- Wrap: preload the counter by driving 2^32−1 retires (or force it), then advance one valid lane → `retire_cnt` = 0.
- HI/LO (macro on): lane0 valid, `mem_whilo` = 1, hi = 0xA, lo = 0xB → `wb_whilo` = 1, `wb_hi` = 0xA, `wb_lo` = 0xB. With `mem_valid[0]` = 0 → `wb_whilo` = 0.
